// File: rtl/idc_scheduler.sv
// Round-robin scheduler sharing one serial ID-checker among NREQ requesters.
// Grants a requester, streams its NDIG digits, waits (with timeout) for the verdict, returns it tagged.
module idc_scheduler #(
    parameter int NREQ    = 4,
    parameter int NDIG    = 10,
    parameter int TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*NDIG*6-1:0]       id_bus,
    output logic                         resp_valid,
    output logic [$clog2(NREQ)-1:0]      resp_idx,
    output logic                         resp_legal,
    output logic                         resp_err,
    output logic                         busy,
    output logic                         chk_in_valid,
    output logic [5:0]                   chk_in_id,
    input  logic                         chk_out_valid,
    input  logic                         chk_out_legal
);

    localparam int IDXW = $clog2(NREQ);
    localparam int IDW  = NDIG * 6;
    localparam int DCW  = $clog2(NDIG + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

    state_t            state_reg, state_next;
    logic [IDXW-1:0]   ptr_reg, ptr_next;
    logic [IDXW-1:0]   idx_reg, idx_next;
    logic [DCW-1:0]    dig_cnt_reg, dig_cnt_next;
    logic [7:0]        wait_cnt_reg, wait_cnt_next;
    logic [IDW-1:0]    id_buf_reg, id_buf_next;
    logic              chk_in_valid_next;
    logic [5:0]        chk_in_id_next;
    logic              resp_valid_next, resp_legal_next, resp_err_next, busy_next;
    logic [IDXW-1:0]   resp_idx_next;

    logic [IDW-1:0]    id_slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign id_slice[gi] = id_bus[gi*IDW +: IDW];
        end
    endgenerate

    // Rotate requests so bit 0 is the requester at the pointer; lowest set bit wins.
    logic [NREQ-1:0]   req_rot;
    logic              gnt_found;
    logic [IDXW:0]     gnt_sum;
    logic [IDXW-1:0]   gnt_idx;

    assign req_rot = NREQ'({req, req} >> ptr_reg);

    always_comb begin
        gnt_found = 1'b0;
        gnt_sum   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_found = 1'b1;
                gnt_sum   = (IDXW+1)'(ptr_reg) + (IDXW+1)'(i);
            end
        end
        if (gnt_sum >= (IDXW+1)'(NREQ)) begin
            gnt_sum = gnt_sum - (IDXW+1)'(NREQ);
        end
        gnt_idx = gnt_sum[IDXW-1:0];
    end

    always_comb begin
        state_next        = state_reg;
        ptr_next          = ptr_reg;
        idx_next          = idx_reg;
        dig_cnt_next      = dig_cnt_reg;
        wait_cnt_next     = wait_cnt_reg;
        id_buf_next       = id_buf_reg;
        chk_in_valid_next = 1'b0;
        chk_in_id_next    = '0;
        resp_valid_next   = 1'b0;
        resp_idx_next     = '0;
        resp_legal_next   = 1'b0;
        resp_err_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (gnt_found) begin
                    state_next        = SEND;
                    idx_next          = gnt_idx;
                    ptr_next          = (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + IDXW'(1);
                    chk_in_valid_next = 1'b1;
                    chk_in_id_next    = id_slice[gnt_idx][5:0];
                    id_buf_next       = id_slice[gnt_idx] >> 6;
                    dig_cnt_next      = '0;
                end
            end
            SEND: begin
                // Digit 0 already went out on the grant edge.
                if (dig_cnt_reg == DCW'(NDIG - 1)) begin
                    state_next    = WAIT;
                    wait_cnt_next = '0;
                end else begin
                    chk_in_valid_next = 1'b1;
                    chk_in_id_next    = id_buf_reg[5:0];
                    id_buf_next       = id_buf_reg >> 6;
                    dig_cnt_next      = dig_cnt_reg + DCW'(1);
                end
            end
            WAIT: begin
                if (chk_out_valid) begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    resp_idx_next   = idx_reg;
                    resp_legal_next = chk_out_legal;
                end else if (wait_cnt_reg == 8'(TIMEOUT - 1)) begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    resp_idx_next   = idx_reg;
                    resp_err_next   = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg      <= '0;
            idx_reg      <= '0;
            dig_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
            id_buf_reg   <= '0;
            chk_in_valid <= 1'b0;
            chk_in_id    <= '0;
            resp_valid   <= 1'b0;
            resp_idx     <= '0;
            resp_legal   <= 1'b0;
            resp_err     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            ptr_reg      <= ptr_next;
            idx_reg      <= idx_next;
            dig_cnt_reg  <= dig_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            id_buf_reg   <= id_buf_next;
            chk_in_valid <= chk_in_valid_next;
            chk_in_id    <= chk_in_id_next;
            resp_valid   <= resp_valid_next;
            resp_idx     <= resp_idx_next;
            resp_legal   <= resp_legal_next;
            resp_err     <= resp_err_next;
            busy         <= busy_next;
        end
    end

endmodule

// File: tb/tb_idc_scheduler.sv
// Bench for idc_scheduler: the bench plays the checker and compares against a transaction-level model.
module tb_idc_scheduler;

    localparam int NREQ    = 4;
    localparam int NDIG    = 10;
    localparam int TIMEOUT = 15;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*NDIG*6-1:0] id_bus;
    logic                   resp_valid;
    logic [1:0]             resp_idx;
    logic                   resp_legal;
    logic                   resp_err;
    logic                   busy;
    logic                   chk_in_valid;
    logic [5:0]             chk_in_id;
    logic                   chk_out_valid;
    logic                   chk_out_legal;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int ptr_m   = 0;
    int txn_no  = 0;

    idc_scheduler #(.NREQ(NREQ), .NDIG(NDIG), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .id_bus(id_bus),
        .resp_valid(resp_valid), .resp_idx(resp_idx), .resp_legal(resp_legal),
        .resp_err(resp_err), .busy(busy), .chk_in_valid(chk_in_valid),
        .chk_in_id(chk_in_id), .chk_out_valid(chk_out_valid), .chk_out_legal(chk_out_legal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_resp_valid"},   32'(resp_valid),   0);
        chk({tag, "_resp_idx"},     32'(resp_idx),     0);
        chk({tag, "_resp_legal"},   32'(resp_legal),   0);
        chk({tag, "_resp_err"},     32'(resp_err),     0);
        chk({tag, "_busy"},         32'(busy),         0);
        chk({tag, "_chk_in_valid"}, 32'(chk_in_valid), 0);
        chk({tag, "_chk_in_id"},    32'(chk_in_id),    0);
    endtask

    // First requesting index at or after the pointer, going around the ring.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int off = 0; off < NREQ; off++) begin
            int i;
            i = (p + off) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic rand_ids();
        for (int i = 0; i < NREQ*NDIG; i++) id_bus[i*6 +: 6] = 6'($urandom_range(0, 63));
    endtask

    // Called just after a negedge with req set; the next posedge is the grant.
    // delay: WAIT edge (1-based) at which the checker answers, 0 = never answers.
    task automatic serve_one(input int delay, input bit legal, input int spur_k, input bit mutate);
        int         w;
        logic [5:0] exp_dig [NDIG];
        bit         exp_err;
        bit         exp_legal;
        w = rr_pick(req, ptr_m);
        chk("grant_exists", 32'(w >= 0), 1);
        if (w < 0) return;
        for (int k = 0; k < NDIG; k++) exp_dig[k] = id_bus[w*NDIG*6 + k*6 +: 6];
        ptr_m     = (w + 1) % NREQ;
        exp_err   = (delay == 0);
        exp_legal = exp_err ? 1'b0 : legal;
        @(posedge clk);
        for (int k = 0; k < NDIG; k++) begin
            @(negedge clk);
            chk("send_valid", 32'(chk_in_valid), 1);
            chk("send_digit", 32'(chk_in_id), 32'(exp_dig[k]));
            chk("send_no_resp", 32'(resp_valid), 0);
            if (k >= 1) chk("send_busy", 32'(busy), 1);
            if (k == 0 && mutate) rand_ids();
            chk_out_valid = (k == spur_k);
            chk_out_legal = 1'($urandom);
            @(posedge clk);
        end
        for (int wi = 1; wi <= TIMEOUT; wi++) begin
            @(negedge clk);
            chk("wait_valid", 32'(chk_in_valid), 0);
            chk("wait_id", 32'(chk_in_id), 0);
            chk("wait_no_resp", 32'(resp_valid), 0);
            chk("wait_busy", 32'(busy), 1);
            chk_out_valid = (wi == delay);
            chk_out_legal = (wi == delay) ? legal : 1'($urandom);
            @(posedge clk);
            if (wi == delay) break;
        end
        @(negedge clk);
        chk("resp_valid", 32'(resp_valid), 1);
        chk("resp_idx", 32'(resp_idx), 32'(w));
        chk("resp_legal", 32'(resp_legal), 32'(exp_legal));
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("resp_busy", 32'(busy), 1);
        $display("txn %0d: idx=%0d legal=%0b err=%0b (expected idx=%0d legal=%0b err=%0b)",
                 txn_no, resp_idx, resp_legal, resp_err, w, exp_legal, exp_err);
        txn_no++;
        req[w]        = 1'b0;
        chk_out_valid = 1'b1;
        chk_out_legal = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_quiet("post_resp");
        chk_out_valid = 1'b0;
    endtask

    initial begin
        int         w;
        logic [5:0] exp_dig [NDIG];
        int         d;
        int         sp;

        rst_n         = 1'b0;
        req           = '0;
        id_bus        = '0;
        chk_out_valid = 1'b0;
        chk_out_legal = 1'b0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst_n         = 1'b1;
        chk_out_valid = 1'b1;
        chk_out_legal = 1'b1;
        @(negedge clk);
        chk_quiet("idle_stray_verdict");
        chk_out_valid = 1'b0;

        // Requester 2 with digits 1..9,0, checker answers in the first WAIT cycle.
        for (int k = 0; k < NDIG; k++) id_bus[2*NDIG*6 + k*6 +: 6] = 6'((k + 1) % 10);
        req = 4'b0100;
        serve_one(1, 1'b1, -1, 1'b0);

        rst_n = 1'b0;
        ptr_m = 0;
        @(negedge clk);
        chk_quiet("idle_reset");
        rst_n = 1'b1;

        // Three simultaneous requests, held until served.
        rand_ids();
        req = 4'b1011;
        repeat (3) serve_one($urandom_range(1, 5), 1'($urandom), -1, 1'b0);

        // Fairness after serving 3.
        req = 4'b1001;
        repeat (2) serve_one($urandom_range(1, 4), 1'($urandom), -1, 1'b0);

        // Timeout then a normal transaction.
        rand_ids();
        req = 4'b0010;
        serve_one(0, 1'b1, -1, 1'b0);
        req = 4'b0010;
        serve_one(TIMEOUT, 1'b1, -1, 1'b0);

        // Spurious verdict during digit 5, id_bus changed after grant, real verdict illegal.
        req = 4'b0001;
        serve_one(4, 1'b0, 5, 1'b1);

        // Reset while digit 4 is on the checker port.
        rand_ids();
        req = 4'b0100;
        w = rr_pick(req, ptr_m);
        for (int k = 0; k < NDIG; k++) exp_dig[k] = id_bus[w*NDIG*6 + k*6 +: 6];
        @(posedge clk);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk("pre_abort_digit", 32'(chk_in_id), 32'(exp_dig[k]));
            if (k < 4) @(posedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk_quiet("async_reset");
        ptr_m = 0;
        req   = '0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_resp", 32'(resp_valid), 0);
        end
        rst_n = 1'b1;
        req   = 4'b1010;
        serve_one(1, 1'b1, -1, 1'b0);
        serve_one(3, 1'b0, -1, 1'b0);

        // Randomized traffic.
        repeat (30) begin
            req = req | 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) rand_ids();
            d  = $urandom_range(1, TIMEOUT + 3);
            if (d > TIMEOUT) d = 0;
            sp = $urandom_range(0, NDIG + 3);
            if (sp >= NDIG) sp = -1;
            serve_one(d, 1'($urandom), sp, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/idc_scheduler.md
# idc_scheduler

Shares a single serial ID-checker core (6-bit digit stream in, one-cycle valid/legal verdict out) among NREQ requesters. Each requester presents a packed NDIG-digit ID; the scheduler arbitrates round-robin, streams the winner's digits into the checker one per cycle, waits for the verdict with a timeout, and returns the result tagged with the requester index. It sits between the requester front-ends and the checker instance, and owns all sequencing of the checker's input port.

## Interface
- NREQ, 4, number of requesters (2..8)
- NDIG, 10, digits per ID
- TIMEOUT, 15, max WAIT cycles before an error verdict (1..255)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level; slice i of id_bus stable while req[i]=1
- id_bus  in  NREQ*NDIG*6  packed IDs; requester i at [i*NDIG*6 +: NDIG*6], digit k at [k*6 +: 6] of that slice
- resp_valid  out  1  one-cycle result pulse
- resp_idx  out  clog2(NREQ)  requester served
- resp_legal  out  1  checker verdict (0 when resp_err)
- resp_err  out  1  checker timed out
- busy  out  1  FSM not in IDLE
- chk_in_valid  out  1  digit strobe to checker
- chk_in_id  out  6  digit to checker
- chk_out_valid  in  1  checker verdict strobe
- chk_out_legal  in  1  checker verdict

## Operation
- All outputs registered; reset value 0 for every output; FSM=IDLE, rr pointer=0, counters=0.
- FSM: IDLE -> SEND -> WAIT -> RESP -> IDLE.
- IDLE: at a clock edge with any req bit set, grant the first set index at or after the pointer (circular), latch that index and its NDIG digits into an internal buffer, pointer <= winner+1 mod NREQ, go SEND. No req: stay.
- SEND: NDIG consecutive cycles, chk_in_valid=1, chk_in_id = digit 0,1,...,NDIG-1 in order; values passed unmodified (0..63). Then WAIT.
- WAIT: chk_in_valid=0, chk_in_id=0. Sample chk_out_valid each edge; on 1, capture chk_out_legal, go RESP with err=0. After TIMEOUT consecutive WAIT edges without it, go RESP with err=1, legal=0.
- RESP: one cycle, resp_valid=1 with resp_idx/resp_legal/resp_err; then IDLE. resp_idx/legal/err return to 0 outside RESP.
- chk_out_valid in IDLE, SEND or RESP is ignored (no state change, no result).
- id_bus is captured at grant; later changes to it do not affect the stream.
- Requester rule: deassert req[i] at the edge ending its resp_valid cycle; if still high in the following IDLE it is treated as a new request (subject to round-robin).
- Reset mid-operation: abort immediately, no resp_valid, pointer to 0; checker shares rst_n and is reset together.

## Timing
- Req sampled at edge E0 (IDLE): chk_in_valid high from E0 to E0+NDIG (cycles 1..NDIG after E0).
- Checker responding in the first WAIT cycle (sampled at E0+NDIG+1): resp_valid high from E0+NDIG+1 to E0+NDIG+2; minimum turnaround 12 cycles at NDIG=10.
- Timeout: resp_valid with err follows the TIMEOUT-th unanswered WAIT edge; max transaction length 1+NDIG+TIMEOUT+1 cycles.
- Minimum gap between transactions: one IDLE cycle after RESP.
- busy=1 from the edge after grant through the RESP cycle.

## Test plan
- Single request on req[2], digits 1,2,3,4,5,6,7,8,9,0; model checker answers legal=1 one cycle after last digit -> chk_in_id sequence exact, resp_valid 12 cycles after grant edge, resp_idx=2, resp_legal=1, resp_err=0.
- req=4'b1011 simultaneously, held until served -> service order 0,1,3, each with correct resp_idx, one IDLE cycle between.
- Fairness: after serving 3, req[0] and req[3] both high -> 0 served first, then 3.
- Checker never answers -> resp_valid after 15 WAIT cycles with resp_err=1, resp_legal=0; next request proceeds normally.
- Spurious chk_out_valid pulse during SEND digit 5 -> ignored; real verdict legal=0 later yields resp_legal=0.
- rst_n low during SEND digit 4 -> all outputs 0 asynchronously, no resp_valid; after release, req[1] high -> full fresh 10-digit stream for requester 1 (pointer restarted at 0).
